l1_icache: RTL

- Direct-mapped, read-only L1 instruction cache. It sits directly upstream of the pipeline IF stage and serves the IF-stage fetch port (address, read, rdata, resp).
- Hits complete in the same cycle. Misses fetch one 128-bit line from physical memory (or from the I/D memory arbiter) and then replay the fetch as a hit.
- The IF-stage stall logic holds the PC until mem_resp, so the datapath needs no further handshake.

---
 rtl/lc3b_types.sv | 16 +
 rtl/l1_icache_array.sv | 56 +++++
 rtl/l1_icache.sv | 104 ++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b types used across the pipeline and memory subsystem.
// Includes the instruction-cache line, offset and FSM state types.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_c_line;
  typedef logic [2:0]   lc3b_c_offset;

  typedef enum logic {
    IDLE,
    FETCH
  } icache_state_t;

  localparam int unsigned LINE_WORDS = 8;

endpackage

// File: rtl/l1_icache_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// One combinational read port, one synchronous line write port.
module icache_array
  import lc3b_types::*;
#(
  parameter int unsigned NUM_LINES = 8,
  parameter int unsigned INDEX_W   = $clog2(NUM_LINES),
  parameter int unsigned TAG_W     = 12 - INDEX_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output lc3b_c_line         rd_line,
  input  logic               we,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  lc3b_c_line         wr_line
);

  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [TAG_W-1:0]     tag_d  [NUM_LINES];
  lc3b_c_line           data_q [NUM_LINES];
  lc3b_c_line           data_d [NUM_LINES];

  // Next-state of the arrays: a fill updates one line and marks it valid.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (we) begin
      valid_d[wr_index] = 1'b1;
      tag_d[wr_index]   = wr_tag;
      data_d[wr_index]  = wr_line;
    end
  end

  // Valid bits clear asynchronously so a reset invalidates every line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) valid_q <= '0;
    else       valid_q <= valid_d;
  end

  // Tag and data need no reset; they are ignored while the line is invalid.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_line  = data_q[rd_index];

endmodule

// File: rtl/l1_icache.sv
// Direct-mapped read-only L1 instruction cache in front of the IF stage.
// Hits answer combinationally; misses fetch a 128-bit line then replay.
module l1_icache
  import lc3b_types::*;
#(
  parameter int unsigned NUM_LINES = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  lc3b_word     mem_address,
  input  logic         mem_read,
  output lc3b_word     mem_rdata,
  output logic         mem_resp,
  output lc3b_word     pmem_address,
  output logic         pmem_read,
  input  lc3b_c_line   pmem_rdata,
  input  logic         pmem_resp
);

  localparam int unsigned INDEX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W   = 12 - INDEX_W;

  icache_state_t state_q, state_d;
  lc3b_word      miss_addr_q, miss_addr_d;

  logic [INDEX_W-1:0] rd_index;
  logic [TAG_W-1:0]   req_tag;
  lc3b_c_offset       req_off;
  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  lc3b_c_line         rd_line;
  logic               hit;
  lc3b_word           hit_word;
  logic               we;
  logic               unused_addr_bit;

  assign rd_index        = mem_address[3+INDEX_W:4];
  assign req_tag         = mem_address[15:4+INDEX_W];
  assign req_off         = mem_address[3:1];
  assign unused_addr_bit = mem_address[0];

  icache_array #(
    .NUM_LINES (NUM_LINES),
    .INDEX_W   (INDEX_W),
    .TAG_W     (TAG_W)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .rd_index (rd_index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .we       (we),
    .wr_index (miss_addr_q[3+INDEX_W:4]),
    .wr_tag   (miss_addr_q[15:4+INDEX_W]),
    .wr_line  (pmem_rdata)
  );

  assign hit      = mem_read & rd_valid & (rd_tag == req_tag);
  assign hit_word = rd_line[{req_off, 4'b0000} +: 16];

  // Miss FSM: latch the line address, hold the read until the fill lands.
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    mem_resp    = 1'b0;
    mem_rdata   = 16'h0000;
    pmem_read   = 1'b0;
    we          = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          mem_resp  = 1'b1;
          mem_rdata = hit_word;
        end else if (mem_read) begin
          miss_addr_d = {mem_address[15:4], 4'b0000};
          state_d     = FETCH;
        end
      end
      FETCH: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          we      = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and miss-address registers; reset abandons any in-flight fill.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      miss_addr_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
    end
  end

  assign pmem_address = miss_addr_q;

endmodule
